// File: rtl/smg_display_arbiter.sv
// -----------------------------------------------------------------------------
// smg_display_arbiter
//
// Shares one hex 7-segment display byte among four requesters. A grant latches
// the winner's byte and holds it for DWELL_CYC cycles. At the end of the dwell
// the block re-arbitrates round-robin, or returns to idle if nobody is asking.
//
// Ports
//   CLK        single clock, rising edge
//   RST        synchronous, active-high reset
//   Req        request vector, Req[k] = requester k wants the display
//   Req_Data   requester k's byte on Req_Data[8k+7:8k]
//   Ack        one-cycle grant pulse, one-hot on the winner
//   Byte_data  byte currently shown
//   Src_Id     requester index whose byte is shown
//   Valid      high while a grant's dwell is running
// -----------------------------------------------------------------------------
module smg_display_arbiter #(
    parameter logic [31:0] DWELL_CYC = 32'd50_000_000,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Req,
    input  logic [31:0] Req_Data,
    output logic [3:0]  Ack,
    output logic [7:0]  Byte_data,
    output logic [1:0]  Src_Id,
    output logic        Valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state;
    logic [31:0] dwell_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  winner;
    logic        expired;
    logic        decide;

    // The counter restarts at 0 on every grant, so the last cycle of a dwell
    // is exactly DWELL_CYC-1 and the counter can never wrap inside a grant.
    assign expired = (dwell_cnt == DWELL_CYC - 32'd1);

    // Round-robin search: last_grant+1 .. last_grant+4 (mod 4). The +4 step
    // lands on last_grant itself, so a lone requester is re-granted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        winner = last_grant;
        decide = (state == ST_IDLE) || expired;
        for (int k = 4; k >= 1; k--) begin
            // Walking from farthest to nearest lets the nearest hit win.
            if (Req[last_grant + 2'(k)]) begin
                winner = last_grant + 2'(k);
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            dwell_cnt  <= 32'd0;
            last_grant <= 2'd3;
            Byte_data  <= IDLE_BYTE;
            Src_Id     <= 2'd0;
            Valid      <= 1'b0;
            Ack        <= 4'b0000;
        end else begin
            Ack <= 4'b0000;
            if (decide) begin
                if (|Req) begin
                    state      <= ST_HOLD;
                    dwell_cnt  <= 32'd0;
                    last_grant <= winner;
                    Byte_data  <= Req_Data[{winner, 3'b000} +: 8];
                    Src_Id     <= winner;
                    Valid      <= 1'b1;
                    Ack        <= 4'b0001 << winner;
                end else begin
                    // Byte_data and Src_Id keep showing the last grant.
                    state     <= ST_IDLE;
                    dwell_cnt <= 32'd0;
                    Valid     <= 1'b0;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_smg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_smg_display_arbiter
//
// Drives two arbiters (dwell 8 and dwell 4) from the same inputs and compares
// both against a behavioural model every cycle, plus literal expectations for
// the directed scenarios.
// -----------------------------------------------------------------------------
module tb_smg_display_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  Req;
    logic [31:0] Req_Data;

    logic [3:0] ack8,  ack4;
    logic [7:0] byte8, byte4;
    logic [1:0] src8,  src4;
    logic       valid8, valid4;

    smg_display_arbiter #(.DWELL_CYC(32'd8), .IDLE_BYTE(8'h00)) dut8 (
        .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data),
        .Ack(ack8), .Byte_data(byte8), .Src_Id(src8), .Valid(valid8)
    );

    smg_display_arbiter #(.DWELL_CYC(32'd4), .IDLE_BYTE(8'h00)) dut4 (
        .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data),
        .Ack(ack4), .Byte_data(byte4), .Src_Id(src4), .Valid(valid4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: dwell 8, 1: dwell 4) -----
    int unsigned dwell  [2] = '{8, 4};
    bit          m_busy [2];
    int unsigned m_left [2];   // cycles of Valid still to show, incl. current
    int          m_last [2];
    logic [7:0]  m_byte [2];
    int          m_src  [2];
    logic [3:0]  m_ack  [2];

    function automatic int rr_pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (req[idx]) return idx;
        end
        return last;
    endfunction

    task automatic model_edge(input logic rst_v, input logic [3:0] req_v, input logic [31:0] data_v);
        for (int i = 0; i < 2; i++) begin
            if (rst_v) begin
                m_busy[i] = 1'b0; m_left[i] = 0; m_last[i] = 3;
                m_byte[i] = 8'h00; m_src[i] = 0; m_ack[i] = 4'b0;
            end else begin
                m_ack[i] = 4'b0;
                if (!m_busy[i] || m_left[i] == 1) begin
                    if (req_v != 4'b0) begin
                        int g;
                        g = rr_pick(m_last[i], req_v);
                        m_byte[i] = 8'((data_v >> (8 * g)) & 32'hFF);
                        m_src[i]  = g;
                        m_last[i] = g;
                        m_ack[i]  = 4'(1 << g);
                        m_busy[i] = 1'b1;
                        m_left[i] = dwell[i];
                    end else begin
                        m_busy[i] = 1'b0;
                    end
                end else begin
                    m_left[i]--;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare #1 later.
    task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [31:0] data_v);
        RST = rst_v; Req = req_v; Req_Data = data_v;
        @(posedge CLK);
        model_edge(rst_v, req_v, data_v);
        #1;
        check("d8_ack",   32'(ack8),   32'(m_ack[0]));
        check("d8_byte",  32'(byte8),  32'(m_byte[0]));
        check("d8_src",   32'(src8),   32'(m_src[0]));
        check("d8_valid", 32'(valid8), 32'(m_busy[0]));
        check("d4_ack",   32'(ack4),   32'(m_ack[1]));
        check("d4_byte",  32'(byte4),  32'(m_byte[1]));
        check("d4_src",   32'(src4),   32'(m_src[1]));
        check("d4_valid", 32'(valid4), 32'(m_busy[1]));
        check("d8_ack_onehot", 32'($countones(ack8) <= 1), 32'd1);
        check("d4_ack_onehot", 32'($countones(ack4) <= 1), 32'd1);
    endtask

    initial begin
        int n_ack;
        bit valid_held;
        int order [$];

        RST = 1'b1; Req = 4'b0; Req_Data = 32'h0;

        // Reset state
        step(1'b1, 4'b0, 32'h0);
        check("rst_byte", 32'(byte8), 32'h00);
        check("rst_src",  32'(src8),  32'd0);
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_ack",  32'(ack8),  32'd0);

        // Single request from requester 2, dwell 8 drop timing
        step(1'b0, 4'b0100, 32'h00A5_0000);
        check("g2_byte",  32'(byte8),  32'hA5);
        check("g2_src",   32'(src8),   32'd2);
        check("g2_valid", 32'(valid8), 32'd1);
        check("g2_ack",   32'(ack8),   32'h4);
        // Active requester's data churns during the hold; display stays frozen
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 4'b0000, $urandom);
            if (c == 1) check("g2_ack_one_cycle", 32'(ack8), 32'd0);
            if (c < 8)  check("hold_byte_frozen", 32'(byte8), 32'hA5);
            if (c == 7) check("valid_before_drop", 32'(valid8), 32'd1);
            if (c == 8) check("valid_dropped", 32'(valid8), 32'd0);
        end
        check("idle_keeps_byte", 32'(byte8), 32'hA5);
        check("idle_keeps_src",  32'(src8),  32'd2);

        // Round robin with all requesting, dwell 4
        step(1'b1, 4'b0, 32'h0);
        valid_held = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 4'b1111, 32'h4433_2211);
            if (ack4 != 4'b0) order.push_back(int'(src4));
            if (!valid4) valid_held = 1'b0;
        end
        check("rr_grants", 32'(order.size()), 32'd4);
        for (int j = 0; j < order.size(); j++) check("rr_order", 32'(order[j]), 32'(j % 4));
        check("rr_valid_continuous", 32'(valid_held), 32'd1);

        // Requester 1 held, requester 3 raised mid-dwell, wins at expiry
        step(1'b1, 4'b0, 32'h0);
        step(1'b0, 4'b0010, 32'h0000_1100);
        check("p1_src", 32'(src4), 32'd1);
        step(1'b0, 4'b0010, 32'h0000_1100);
        step(1'b0, 4'b0010, 32'h0000_1100);
        step(1'b0, 4'b1010, 32'h3300_1100);
        step(1'b0, 4'b1010, 32'h3300_1100);
        check("p3_ack",   32'(ack4),   32'h8);
        check("p3_src",   32'(src4),   32'd3);
        check("p3_byte",  32'(byte4),  32'h33);
        check("p3_valid", 32'(valid4), 32'd1);

        // Reset on the expiry edge, then 1001 grants requester 0 first
        step(1'b1, 4'b0, 32'h0);
        step(1'b0, 4'b1001, 32'hDD00_00C0);
        step(1'b0, 4'b1001, 32'hDD00_00C0);
        step(1'b0, 4'b1001, 32'hDD00_00C0);
        step(1'b0, 4'b1001, 32'hDD00_00C0);
        step(1'b1, 4'b1001, 32'hDD00_00C0);
        check("rx_ack",   32'(ack4),   32'd0);
        check("rx_valid", 32'(valid4), 32'd0);
        check("rx_byte",  32'(byte4),  32'h00);
        check("rx_src",   32'(src4),   32'd0);
        step(1'b0, 4'b1001, 32'hDD00_00C0);
        check("rx_first_ack", 32'(ack4), 32'h1);
        check("rx_first_byte", 32'(byte4), 32'hC0);

        // Lone requester 2 re-granted every dwell period
        step(1'b1, 4'b0, 32'h0);
        n_ack = 0; valid_held = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'b0100, 32'h0077_0000);
            if (ack4[2]) n_ack++;
            if (!valid4) valid_held = 1'b0;
        end
        check("lone_regrants", 32'(n_ack), 32'd3);
        check("lone_valid_held", 32'(valid_held), 32'd1);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            step(($urandom_range(0, 63) == 0), r, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/smg_display_arbiter.md
SMG_DISPLAY_ARBITER -- requirements
Module: smg_display_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 32'd50_000_000, meaning display hold time per grant in CLK cycles (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'h00, meaning the byte presented after reset, before the first grant.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Req, input, 4 bits: Req[k] high means requester k asks for the display.
REQ-006 SHALL have port Req_Data, input, 32 bits: requester k's byte on Req_Data[8k+7:8k].
REQ-007 SHALL have port Ack, output, 4 bits: one-cycle grant pulse to requester k.
REQ-008 SHALL have port Byte_data, output, 8 bits: byte sent to the hex 7-segment display datapath.
REQ-009 SHALL have port Src_Id, output, 2 bits: index of the requester whose byte is shown.
REQ-010 SHALL have port Valid, output, 1 bit: high while a grant's dwell is running.

Function
REQ-011 SHALL implement FSM states IDLE and HOLD, with all outputs registered.
REQ-012 In IDLE with Req==0, the block SHALL stay in IDLE with Valid=0 and Ack=0, and Byte_data/Src_Id SHALL keep their last values.
REQ-013 In IDLE with Req!=0, the next edge SHALL grant winner g and then: latch Byte_data<=Req_Data[8g+7:8g], Src_Id<=g, Valid<=1, Ack<=one-hot(g), dwell counter<=0, state<=HOLD, last_grant<=g.
REQ-014 Arbitration SHALL be round-robin: search order last_grant+1, +2, +3, +4 (mod 4); the first requester with Req set wins.
REQ-015 Ack SHALL be high for exactly one cycle per grant, only on the winner's bit, and never on more than one bit.
REQ-016 In HOLD, the dwell counter SHALL increment by 1 each cycle; Byte_data and Src_Id SHALL stay frozen regardless of Req or Req_Data changes.
REQ-017 When the counter reaches DWELL_CYC-1 with Req!=0, the block SHALL re-arbitrate on that edge per REQ-013/014 with no idle gap, so Valid stays 1.
REQ-018 When the counter reaches DWELL_CYC-1 with Req==0, the block SHALL go to IDLE and set Valid<=0, keeping Byte_data and Src_Id.
REQ-019 The winning requester's Req is not masked: if it is still high at expiry and no other request is pending, it SHALL be re-granted.
REQ-020 Arbitration SHALL use Req only at the decision edge; a Req pulse that is high only during HOLD and gone by expiry SHALL be ignored.
REQ-021 Grant-to-display latency SHALL be 1 cycle from the Req sample edge to the Byte_data, Valid and Ack updates.
REQ-022 The dwell counter SHALL be 32 bits, compare exactly against DWELL_CYC-1, and never wrap inside a grant.

Reset
REQ-023 RST high at a clock edge SHALL force state=IDLE, Byte_data=IDLE_BYTE, Src_Id=0, Valid=0, Ack=0, counter=0 and last_grant=3, so requester 0 has first priority.
REQ-024 RST SHALL take precedence over every other event, including a simultaneous grant or expiry; no Ack SHALL be issued in that cycle.
REQ-025 Reset asserted mid-HOLD SHALL abandon the grant; after RST deasserts, arbitration SHALL restart from requester 0.

Verification
REQ-026 Reset, then Req=4'b0100 with data 8'hA5 for one cycle: next cycle Byte_data=8'hA5, Src_Id=2, Valid=1, Ack=4'b0100 for 1 cycle; with DWELL_CYC=8, Valid drops 8 cycles after the grant.
REQ-027 With DWELL_CYC=4, hold Req=4'b1111 constantly: grant order 0,1,2,3,0,... with one grant every 4 cycles, Valid continuously 1, and exactly one Ack pulse per grant.
REQ-028 Grant requester 1 and hold Req[1]=1; raise Req[3] mid-dwell: at expiry requester 3 wins, with no gap cycle.
REQ-029 During HOLD, change Req_Data of the active requester every cycle: Byte_data stays at the value latched at grant.
REQ-030 Assert RST on the same edge as a dwell expiry with Req!=0: outputs equal reset values, Ack=0; after release, Req=4'b1001 grants requester 0 first.
REQ-031 Requester 2 alone keeps Req high across expiry: it is re-granted with Ack[2] pulsing once per dwell period, and Valid never drops.
